// File: rtl/motor_pwm_decoder.sv
// H-bridge fwd/rev PWM pair decoder: recovers a signed-magnitude
// drive command, brake and fault flags over a fixed 2^PWM_BITS window.
module motor_pwm_decoder #(
  parameter int PWM_BITS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fwd_in,
  input  logic              rev_in,
  input  logic              clr,
  output logic [PWM_BITS:0] cmd,
  output logic              valid,
  output logic              brake,
  output logic              fault,
  output logic              fault_sticky
);

  localparam logic [PWM_BITS:0] W_FULL =
    {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [PWM_BITS-1:0] W_LAST = '1;
  localparam logic [PWM_BITS-1:0] W_ONE =
    {{(PWM_BITS-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_ACQ,
    ST_TRACK
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic r_fwd_meta;
  logic r_fwd_sync;
  logic r_rev_meta;
  logic r_rev_sync;

  logic [PWM_BITS-1:0] r_wcnt;
  logic [PWM_BITS:0]   r_f_cnt;
  logic [PWM_BITS:0]   r_r_cnt;
  logic [PWM_BITS:0]   r_b_cnt;

  logic [PWM_BITS:0] r_cmd;
  logic              r_valid;
  logic              r_brake;
  logic              r_fault;
  logic              r_sticky;

  logic              w_end;
  logic              w_eval;
  logic              w_f_inc;
  logic              w_r_inc;
  logic              w_b_inc;
  logic [PWM_BITS:0] w_f_fin;
  logic [PWM_BITS:0] w_r_fin;
  logic [PWM_BITS:0] w_b_fin;
  logic              w_hit;
  logic [PWM_BITS:0] w_cmd_n;
  logic              w_brake_n;

  function automatic logic [PWM_BITS-1:0] sat(
    input logic [PWM_BITS:0] x
  );
    if (x == W_FULL) return '1;
    return x[PWM_BITS-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_meta <= 1'b0;
      r_fwd_sync <= 1'b0;
      r_rev_meta <= 1'b0;
      r_rev_sync <= 1'b0;
    end else begin
      r_fwd_meta <= fwd_in;
      r_fwd_sync <= r_fwd_meta;
      r_rev_meta <= rev_in;
      r_rev_sync <= r_rev_meta;
    end
  end

  assign w_end   = (r_wcnt == W_LAST);
  assign w_f_inc = r_fwd_sync & ~r_rev_sync;
  assign w_r_inc = r_rev_sync & ~r_fwd_sync;
  assign w_b_inc = r_fwd_sync & r_rev_sync;

  // Final counts include the sample of the window-end cycle itself
  assign w_f_fin = r_f_cnt + {{PWM_BITS{1'b0}}, w_f_inc};
  assign w_r_fin = r_r_cnt + {{PWM_BITS{1'b0}}, w_r_inc};
  assign w_b_fin = r_b_cnt + {{PWM_BITS{1'b0}}, w_b_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt  <= '0;
      r_f_cnt <= '0;
      r_r_cnt <= '0;
      r_b_cnt <= '0;
    end else if (clr) begin
      r_wcnt  <= '0;
      r_f_cnt <= '0;
      r_r_cnt <= '0;
      r_b_cnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + W_ONE;
      if (w_end) begin
        r_f_cnt <= '0;
        r_r_cnt <= '0;
        r_b_cnt <= '0;
      end else begin
        r_f_cnt <= w_f_fin;
        r_r_cnt <= w_r_fin;
        r_b_cnt <= w_b_fin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACQ;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_eval    = 1'b0;
    if (clr) begin
      w_state_n = ST_ACQ;
    end else if (w_end) begin
      unique case (r_state)
        ST_ACQ:   w_state_n = ST_TRACK;
        ST_TRACK: w_eval    = 1'b1;
        default:  w_state_n = ST_ACQ;
      endcase
    end
  end

  // Priority: fault, full-window brake, reverse, forward/coast
  always_comb begin
    w_hit     = (w_f_fin != '0) && (w_r_fin != '0);
    w_cmd_n   = r_cmd;
    w_brake_n = 1'b0;
    if (w_hit) begin
      w_cmd_n = r_cmd;
    end else if (w_b_fin == W_FULL) begin
      w_cmd_n   = '0;
      w_brake_n = 1'b1;
    end else if (w_r_fin != '0) begin
      w_cmd_n = {1'b1, sat(w_r_fin)};
    end else begin
      w_cmd_n = {1'b0, sat(w_f_fin)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd    <= '0;
      r_valid  <= 1'b0;
      r_brake  <= 1'b0;
      r_fault  <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_valid <= w_eval;
      if (w_eval) begin
        r_cmd   <= w_cmd_n;
        r_brake <= w_brake_n;
        r_fault <= w_hit;
      end
      if (clr) begin
        r_sticky <= 1'b0;
      end else if (w_eval && w_hit) begin
        r_sticky <= 1'b1;
      end
    end
  end

  assign cmd          = r_cmd;
  assign valid        = r_valid;
  assign brake        = r_brake;
  assign fault        = r_fault;
  assign fault_sticky = r_sticky;

endmodule

// File: doc/motor_pwm_decoder.md
Name: motor_pwm_decoder

Overview:
- Recovers the signed-magnitude drive command from one H-bridge channel's fwd/rev PWM pair. This is the decoder end of the motor drive interface.
- Counts fwd-high, rev-high and both-high cycles over a fixed window of 2^PWM_BITS clocks. At each window end it publishes an 11-bit command: bit 10 = reverse, bits 9:0 = magnitude. It also publishes brake and fault flags.
- Instantiated once per motor. Used for closed-loop self-check of the drive path and as a bench monitor.

Parameters:
- PWM_BITS, 10, PWM counter width. Window length W = 2^PWM_BITS clocks; magnitude width = PWM_BITS.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- fwd_in, input, 1, forward PWM from the bridge driver; may be asynchronous.
- rev_in, input, 1, reverse PWM from the bridge driver; may be asynchronous.
- clr, input, 1, synchronous restart: clears the window and the sticky fault, and re-enters ACQ.
- cmd, output, PWM_BITS+1, decoded command {dir, magnitude}.
- valid, output, 1, one-cycle pulse when cmd/brake/fault update.
- brake, output, 1, last window had fwd and rev both high for all W cycles.
- fault, output, 1, last window had fwd-only and rev-only cycles both nonzero.
- fault_sticky, output, 1, set by any fault window; cleared only by clr or reset.

Behaviour:
- Reset values (all outputs and state):
  - cmd = 0, valid = 0, brake = 0, fault = 0, fault_sticky = 0.
  - State = ACQ.
  - Window counter and all accumulators = 0.
  - Synchronizer flops = 0.
- Input sync: fwd_in and rev_in each pass through a 2-flop synchronizer. All counting uses the synchronized samples fs and rs, which lag the pins by 2 cycles.
- Window counter:
  - wcnt is PWM_BITS wide, increments every cycle and wraps W-1 -> 0.
  - The window end is the cycle with wcnt == W-1.
- Accumulators, each PWM_BITS+1 bits, one class per cycle:
  - f_cnt counts fs & !rs.
  - r_cnt counts rs & !fs.
  - b_cnt counts fs & rs.
  - Both low counts nothing (coast).
  - Max value per window is W, so no overflow is possible.
- End-of-window evaluation uses the final counts, including the sample taken in the wcnt == W-1 cycle. Rules apply in priority order:
  1. f_cnt != 0 and r_cnt != 0: fault = 1, fault_sticky = 1, brake = 0, cmd holds its previous value.
  2. b_cnt == W: cmd = 0, brake = 1, fault = 0.
  3. r_cnt != 0: cmd = {1, sat(r_cnt)}, brake = 0, fault = 0.
  4. Otherwise (forward, or all low): cmd = {0, sat(f_cnt)}, brake = 0, fault = 0. All low gives cmd = 0.
  - sat(x) = W-1 if x == W, else x[PWM_BITS-1:0].
  - Partial both-high cycles (b_cnt < W) are ignored for brake detection.
- Update timing:
  - Accumulators restart at 0 on the cycle after the window end, with no lost sample.
  - cmd, brake, fault and valid update on the clock edge that ends the wcnt == W-1 cycle.
  - valid is high for exactly one cycle; rising edge every W cycles in TRACK.
- State machine:
  - ACQ: first window after reset or clr. Runs a full window with the accumulators active, but the end-of-window result is discarded: no valid pulse, outputs unchanged. ACQ -> TRACK at window end.
  - TRACK: every window end evaluates and pulses valid. Stays in TRACK until clr or reset.
- Window alignment: the window is free-running and not phase-locked to the PWM. For a PWM of period W, any W-cycle window yields the exact duty, so phase does not matter.
- clr:
  - Next state: wcnt = 0, accumulators = 0, fault_sticky = 0, state = ACQ, valid = 0.
  - cmd, brake and fault keep their values.
  - clr during the window-end cycle takes priority: no evaluation and no valid pulse.
  - Synchronizer flops are not cleared.
- Reset asserted mid-window: all state is cleared immediately (asynchronous). The next valid appears only after a full ACQ window plus a full TRACK window.
- Input changes mid-window: counts reflect the mix of the old and new signals. The next window is exact.

Test Plan:
- Forward duty: fwd = PWM with duty 300, rev = 0, W = 1024, run 4 windows -> first valid at cycle ~2048 after reset; every valid shows cmd = 0x12C, brake = 0, fault = 0; valid pulses spaced exactly 1024 cycles.
- Reverse full scale: rev held high, fwd = 0 -> cmd = 0x7FF (dir = 1, magnitude saturated to 1023 from count 1024).
- Brake and coast: fwd = rev = 1 for whole windows -> cmd = 0, brake = 1. Then both = 0 -> next valid shows cmd = 0, brake = 0.
- Fault: fwd pulsed high 10 cycles and rev pulsed high 10 cycles (not overlapping) in one window, starting from cmd = 0x12C -> fault = 1, fault_sticky = 1, cmd stays 0x12C. Next clean window -> fault = 0, fault_sticky stays 1 until a clr pulse clears it.
- Phase independence: duty 500 PWM started at random offsets 0..1023 relative to reset -> every TRACK valid gives cmd = 0x1F4.
- clr and reset mid-operation: clr asserted on a wcnt == W-1 cycle -> no valid that cycle, next valid after 2048 cycles. rst_n pulsed low mid-window -> all outputs 0 immediately.
